fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving instruction slots (power of 2, at least FETCH_WIDTH and at least DEC_WIDTH).
REQ-002 The block SHALL have parameter FETCH_WIDTH, default 2, giving instructions per ICache packet.
REQ-003 The block SHALL have parameter DEC_WIDTH, default 2, giving instructions presented to the decoder per cycle.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port flush, input, 1 bit: discards all buffered instructions.
REQ-007 The block SHALL have port cache_stall, input, 1 bit: freezes all state.
REQ-008 The block SHALL have port fetch_pc, input, CPU_ADDR_BITS: PC of packet slot 0.
REQ-009 The block SHALL have port icache_dout, input, FETCH_WIDTH*CPU_INST_BITS: packet, slot i at bits [i*CPU_INST_BITS +: CPU_INST_BITS].
REQ-010 The block SHALL have port icache_cnt, input, $clog2(FETCH_WIDTH+1): count of valid low-order slots.
REQ-011 The block SHALL have port icache_dout_val, input, 1 bit: packet valid.
REQ-012 The block SHALL have port inst_buffer_rdy, output, 1 bit: room for a full packet.
REQ-013 The block SHALL have port dec_pc, output, DEC_WIDTH*CPU_ADDR_BITS: per-slot PC.
REQ-014 The block SHALL have port dec_inst, output, DEC_WIDTH*CPU_INST_BITS: per-slot instruction.
REQ-015 The block SHALL have port dec_val, output, DEC_WIDTH: bit k set iff occupancy > k.
REQ-016 The block SHALL have port dec_take, input, $clog2(DEC_WIDTH+1): number of slots the decoder consumes this cycle.
REQ-017 The block SHALL have port occupancy, output, $clog2(DEPTH+1): current instruction count.

Function
REQ-018 The block SHALL be an instruction-granular circular FIFO with read/write pointers modulo DEPTH and a separate occupancy counter, so all DEPTH slots are usable.
REQ-019 The block SHALL set inst_buffer_rdy = (DEPTH - occupancy >= FETCH_WIDTH), computed from registered occupancy only, with no same-cycle dequeue credit.
REQ-020 The block SHALL accept a write when icache_dout_val && inst_buffer_rdy && !cache_stall && !flush.
REQ-021 On an accepted write, the block SHALL store min(icache_cnt, FETCH_WIDTH) instructions at consecutive slots from write_ptr, giving slot i PC fetch_pc + 4*i.
REQ-022 An accepted write with icache_cnt=0 SHALL be a no-op.
REQ-023 Decoder outputs SHALL be combinational from storage: output slot k shows entry (read_ptr+k) mod DEPTH, with zero-cycle read latency.
REQ-024 The effective dequeue SHALL be min(dec_take, occupancy, DEC_WIDTH); it is applied when !cache_stall && !flush, and read_ptr advances by that amount.
REQ-025 On simultaneous read and write, occupancy_next SHALL equal occupancy + written - dequeued, and a write never overwrites a slot being read in the same cycle.
REQ-026 Pointers SHALL wrap modulo DEPTH; a packet straddling the wrap SHALL be split across slots DEPTH-1 and 0 without gaps.
REQ-027 Priority SHALL be rst > flush > cache_stall > normal operation.
REQ-028 Flush SHALL zero both pointers and occupancy in one cycle; any same-cycle write is dropped.
REQ-029 cache_stall SHALL hold pointers, occupancy and storage; outputs remain driven.
REQ-030 Storage contents in unoccupied slots SHALL be don't-care; dec_pc/dec_inst for slots with dec_val=0 are don't-care.

Reset
REQ-031 On rst, the block SHALL set read_ptr=0, write_ptr=0 and occupancy=0 on the next edge; storage is not reset.
REQ-032 After reset, outputs SHALL be inst_buffer_rdy=1, dec_val=0 and occupancy=0.
REQ-033 rst asserted mid-operation SHALL discard all contents, identically to flush.

Configuration
REQ-034 With macro FETCH_BUFFER_PERF_EN defined, the block SHALL add output full_cycles (32 bits), counting cycles with inst_buffer_rdy=0 and saturating at all-ones.
REQ-035 With FETCH_BUFFER_PERF_EN defined, the block SHALL add output occ_hwm ($clog2(DEPTH+1) bits), holding the maximum occupancy seen.
REQ-036 full_cycles and occ_hwm SHALL clear on rst only; flush and cache_stall do not clear them, and full_cycles keeps counting during cache_stall.
REQ-037 Without FETCH_BUFFER_PERF_EN, the ports and logic SHALL be absent and behaviour is otherwise identical.

Verification
REQ-038 Reset, then fetch_pc=0x100, icache_cnt=2, dec_take=0 -> next cycle occupancy=2, dec_val=2'b11, dec_pc={0x104,0x100}.
REQ-039 DEPTH=8, 4 full packets written, no reads -> occupancy=8, inst_buffer_rdy=0; a 5th valid packet is dropped and contents are unchanged.
REQ-040 occupancy=1, dec_take=2 with simultaneous write icache_cnt=2 -> dequeue 1 only, occupancy=2, no corruption.
REQ-041 write_ptr=7, write icache_cnt=2 at fetch_pc=0x200 -> slots 7 and 0 hold PCs 0x200 and 0x204; the decoder sees them in order.
REQ-042 occupancy=5, cache_stall=1 with a valid write and dec_take=2 -> state unchanged; then flush=1 with a valid write -> occupancy=0, dec_val=0.
REQ-043 With FETCH_BUFFER_PERF_EN, fill to 8 and hold 3 cycles, then flush -> occ_hwm=8, full_cycles=3, and both are unchanged by the flush.

Source files
------------

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction-granular fetch buffer between ICache and decoder
//
// Purpose: circular FIFO of DEPTH instruction slots. Accepts up to FETCH_WIDTH
// instructions per ICache packet and presents DEC_WIDTH head instructions to
// the decoder combinationally; the decoder consumes up to DEC_WIDTH per cycle.
//
// Optional feature: define FETCH_BUFFER_PERF_EN to add the performance
// counters full_cycles and occ_hwm.
//
// Ports:
//   clk             - clock, all state updates on the rising edge
//   rst             - synchronous active-high reset (clears pointers/occupancy)
//   flush           - discard all buffered instructions
//   cache_stall     - freeze all state
//   fetch_pc        - PC of packet slot 0
//   icache_dout     - packet, slot i at [i*CPU_INST_BITS +: CPU_INST_BITS]
//   icache_cnt      - number of valid low-order packet slots
//   icache_dout_val - packet valid
//   inst_buffer_rdy - room for a full packet (from registered occupancy)
//   dec_pc          - per-slot PC presented to the decoder
//   dec_inst        - per-slot instruction presented to the decoder
//   dec_val         - bit k set iff occupancy > k
//   dec_take        - number of slots the decoder consumes this cycle
//   occupancy       - current instruction count
//   full_cycles     - (perf) cycles with inst_buffer_rdy=0, saturating
//   occ_hwm         - (perf) maximum occupancy seen

module fetch_buffer #(
  parameter int DEPTH         = 8,
  parameter int FETCH_WIDTH   = 2,
  parameter int DEC_WIDTH     = 2,
  parameter int CPU_ADDR_BITS = 32,
  parameter int CPU_INST_BITS = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 cache_stall,
  input  logic [CPU_ADDR_BITS-1:0]             fetch_pc,
  input  logic [FETCH_WIDTH*CPU_INST_BITS-1:0] icache_dout,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]     icache_cnt,
  input  logic                                 icache_dout_val,
  output logic                                 inst_buffer_rdy,
  output logic [DEC_WIDTH*CPU_ADDR_BITS-1:0]   dec_pc,
  output logic [DEC_WIDTH*CPU_INST_BITS-1:0]   dec_inst,
  output logic [DEC_WIDTH-1:0]                 dec_val,
  input  logic [$clog2(DEC_WIDTH+1)-1:0]       dec_take,
`ifdef FETCH_BUFFER_PERF_EN
  output logic [31:0]                          full_cycles,
  output logic [$clog2(DEPTH+1)-1:0]           occ_hwm,
`endif
  output logic [$clog2(DEPTH+1)-1:0]           occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam int CW = $clog2(FETCH_WIDTH+1);

  localparam logic [OW:0]   DEPTH_X = DEPTH[OW:0];
  localparam logic [OW:0]   FW_X    = FETCH_WIDTH[OW:0];
  localparam logic [CW-1:0] FW_C    = FETCH_WIDTH[CW-1:0];
  localparam logic [OW-1:0] DW_O    = DEC_WIDTH[OW-1:0];

  logic [CPU_ADDR_BITS-1:0] r_mem_pc   [DEPTH];
  logic [CPU_INST_BITS-1:0] r_mem_inst [DEPTH];
  logic [PW-1:0]            r_rd_ptr;
  logic [PW-1:0]            r_wr_ptr;
  logic [OW-1:0]            r_occ;

  logic [OW:0]              w_free;
  logic                     w_wr_en;
  logic [CW-1:0]            w_wr_cnt;
  logic [OW-1:0]            w_deq;
  logic [OW-1:0]            w_occ_next;
  logic [OW-1:0]            w_occ_final;
  logic [PW-1:0]            w_wr_idx  [FETCH_WIDTH];
  logic                     w_slot_we [FETCH_WIDTH];
  logic [CPU_ADDR_BITS-1:0] w_slot_pc [FETCH_WIDTH];
  logic [PW-1:0]            w_rd_idx  [DEC_WIDTH];

  // Ready uses registered occupancy only; slots freed by this cycle's
  // dequeue are not credited, so an accepted packet always lands in slots
  // that are already free and never collides with a slot being read.
  assign w_free          = DEPTH_X - {1'b0, r_occ};
  assign inst_buffer_rdy = (w_free >= FW_X);
  assign w_wr_en         = icache_dout_val && inst_buffer_rdy && !cache_stall && !flush && !rst;
  assign occupancy       = r_occ;

  always_comb begin
    w_wr_cnt = '0;
    if (w_wr_en) begin
      w_wr_cnt = (icache_cnt > FW_C) ? FW_C : icache_cnt;
    end
  end

  // Effective dequeue = min(dec_take, occupancy, DEC_WIDTH), only when live.
  always_comb begin
    w_deq = OW'(dec_take);
    if (w_deq > DW_O) begin
      w_deq = DW_O;
    end
    if (w_deq > r_occ) begin
      w_deq = r_occ;
    end
    if (cache_stall || flush || rst) begin
      w_deq = '0;
    end
  end

  assign w_occ_next = r_occ + OW'(w_wr_cnt) - w_deq;

  // Occupancy value after this edge, after applying priority.
  always_comb begin
    w_occ_final = w_occ_next;
    if (rst || flush) begin
      w_occ_final = '0;
    end else if (cache_stall) begin
      w_occ_final = r_occ;
    end
  end

  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_wr_idx[i]  = r_wr_ptr + PW'(i);
      w_slot_we[i] = (i < int'(w_wr_cnt));
      w_slot_pc[i] = fetch_pc + CPU_ADDR_BITS'(4 * i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else if (!cache_stall) begin
      // Pointer widths equal log2(DEPTH), so wrap is the natural overflow.
      r_rd_ptr <= r_rd_ptr + w_deq[PW-1:0];
      r_wr_ptr <= r_wr_ptr + w_wr_cnt[PW-1:0];
      r_occ    <= w_occ_next;
    end
  end

  // Storage is not reset; slot write enables are already gated by w_wr_en.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (w_slot_we[i]) begin
        r_mem_pc[w_wr_idx[i]]   <= w_slot_pc[i];
        r_mem_inst[w_wr_idx[i]] <= icache_dout[i*CPU_INST_BITS +: CPU_INST_BITS];
      end
    end
  end

  always_comb begin
    dec_pc   = '0;
    dec_inst = '0;
    dec_val  = '0;
    for (int k = 0; k < DEC_WIDTH; k++) begin
      w_rd_idx[k] = r_rd_ptr + PW'(k);
      dec_pc[k*CPU_ADDR_BITS +: CPU_ADDR_BITS]   = r_mem_pc[w_rd_idx[k]];
      dec_inst[k*CPU_INST_BITS +: CPU_INST_BITS] = r_mem_inst[w_rd_idx[k]];
      dec_val[k] = (r_occ > OW'(k));
    end
  end

`ifdef FETCH_BUFFER_PERF_EN
  logic [31:0]   r_full_cycles;
  logic [OW-1:0] r_occ_hwm;

  // Counters survive flush and keep running through cache_stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full_cycles <= '0;
      r_occ_hwm     <= '0;
    end else begin
      if (!inst_buffer_rdy && (r_full_cycles != '1)) begin
        r_full_cycles <= r_full_cycles + 32'd1;
      end
      if (w_occ_final > r_occ_hwm) begin
        r_occ_hwm <= w_occ_final;
      end
    end
  end

  assign full_cycles = r_full_cycles;
  assign occ_hwm     = r_occ_hwm;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - scoreboard testbench for fetch_buffer
module tb_fetch_buffer;

  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int DW    = 2;
  localparam int AB    = 32;
  localparam int IB    = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              flush;
  logic              cache_stall;
  logic [AB-1:0]     fetch_pc;
  logic [FW*IB-1:0]  icache_dout;
  logic [1:0]        icache_cnt;
  logic              icache_dout_val;
  logic              inst_buffer_rdy;
  logic [DW*AB-1:0]  dec_pc;
  logic [DW*IB-1:0]  dec_inst;
  logic [DW-1:0]     dec_val;
  logic [1:0]        dec_take;
  logic [3:0]        occupancy;
`ifdef FETCH_BUFFER_PERF_EN
  logic [31:0]       full_cycles;
  logic [3:0]        occ_hwm;
`endif

  fetch_buffer #(
    .DEPTH(DEPTH), .FETCH_WIDTH(FW), .DEC_WIDTH(DW),
    .CPU_ADDR_BITS(AB), .CPU_INST_BITS(IB)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .cache_stall(cache_stall),
    .fetch_pc(fetch_pc), .icache_dout(icache_dout), .icache_cnt(icache_cnt),
    .icache_dout_val(icache_dout_val), .inst_buffer_rdy(inst_buffer_rdy),
    .dec_pc(dec_pc), .dec_inst(dec_inst), .dec_val(dec_val), .dec_take(dec_take),
`ifdef FETCH_BUFFER_PERF_EN
    .full_cycles(full_cycles), .occ_hwm(occ_hwm),
`endif
    .occupancy(occupancy)
  );

  typedef struct packed {
    logic [AB-1:0] pc;
    logic [IB-1:0] inst;
  } ent_t;

  ent_t   sb[$];
  int     n_checks = 0;
  int     n_fails  = 0;
  longint m_full   = 0;
  int     m_hwm    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check head/ready against the scoreboard,
  // advance the model, clock, then check occupancy and counters.
  task automatic cycle(input logic r, input logic fl, input logic st, input logic val,
                       input logic [AB-1:0] pc, input logic [1:0] cnt, input logic [1:0] take);
    logic m_rdy;
    int   ncnt;
    int   ndeq;
    rst = r; flush = fl; cache_stall = st; icache_dout_val = val;
    fetch_pc = pc; icache_cnt = cnt; dec_take = take;
    icache_dout = {$urandom, $urandom};
    #1;
    m_rdy = ((DEPTH - sb.size()) >= FW);
    check("rdy", inst_buffer_rdy, m_rdy);
    for (int k = 0; k < DW; k++) begin
      check("dec_val", dec_val[k], sb.size() > k);
      if (sb.size() > k) begin
        check("dec_pc", dec_pc[k*AB +: AB], sb[k].pc);
        check("dec_inst", dec_inst[k*IB +: IB], sb[k].inst);
      end
    end
    if (r) begin
      sb.delete();
      m_full = 0;
      m_hwm  = 0;
    end else begin
      if (!m_rdy && m_full != 64'hFFFF_FFFF) m_full++;
      if (fl) begin
        sb.delete();
      end else if (!st) begin
        ndeq = take;
        if (ndeq > DW) ndeq = DW;
        if (ndeq > sb.size()) ndeq = sb.size();
        repeat (ndeq) void'(sb.pop_front());
        if (val && m_rdy) begin
          ncnt = (cnt > FW) ? FW : cnt;
          for (int i = 0; i < ncnt; i++)
            sb.push_back('{pc: pc + AB'(4 * i), inst: icache_dout[i*IB +: IB]});
        end
      end
      if (sb.size() > m_hwm) m_hwm = sb.size();
    end
    @(posedge clk);
    #1;
    check("occupancy", occupancy, sb.size());
`ifdef FETCH_BUFFER_PERF_EN
    check("full_cycles", full_cycles, m_full);
    check("occ_hwm", occ_hwm, m_hwm);
`endif
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cache_stall = 1'b0; icache_dout_val = 1'b0;
    fetch_pc = '0; icache_dout = '0; icache_cnt = '0; dec_take = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_occupancy", occupancy, 4'd0);
    check("reset_rdy", inst_buffer_rdy, 1'b1);
    check("reset_dec_val", dec_val, 2'b00);

    // First packet appears at the head the next cycle.
    cycle(0, 0, 0, 1, 32'h100, 2'd2, 2'd0);
    check("first_dec_val", dec_val, 2'b11);
    check("first_dec_pc", dec_pc, 64'h0000_0104_0000_0100);

    // Fill to DEPTH; the following packet is dropped.
    cycle(0, 0, 0, 1, 32'h108, 2'd2, 2'd0);
    cycle(0, 0, 0, 1, 32'h110, 2'd2, 2'd0);
    cycle(0, 0, 0, 1, 32'h118, 2'd2, 2'd0);
    check("full_occupancy", occupancy, 4'd8);
    check("full_rdy", inst_buffer_rdy, 1'b0);
    cycle(0, 0, 0, 1, 32'h900, 2'd2, 2'd0);
    cycle(0, 0, 0, 0, 32'h0, 2'd0, 2'd0);

    // Down to 5, then stall with live write and take, then flush with write.
    cycle(0, 0, 0, 0, 32'h0, 2'd0, 2'd2);
    cycle(0, 0, 0, 0, 32'h0, 2'd0, 2'd1);
    check("occ_five", occupancy, 4'd5);
    cycle(0, 0, 1, 1, 32'h500, 2'd2, 2'd2);
    check("stall_hold", occupancy, 4'd5);
    cycle(0, 1, 0, 1, 32'h600, 2'd2, 2'd2);
    check("flush_occ", occupancy, 4'd0);
    check("flush_dec_val", dec_val, 2'b00);

    // Move write pointer to 7, drain to 1, then write across the wrap
    // while asking for more than is buffered.
    cycle(0, 0, 0, 1, 32'h300, 2'd2, 2'd0);
    cycle(0, 0, 0, 1, 32'h308, 2'd2, 2'd0);
    cycle(0, 0, 0, 1, 32'h310, 2'd2, 2'd0);
    cycle(0, 0, 0, 1, 32'h318, 2'd1, 2'd0);
    cycle(0, 0, 0, 0, 32'h0, 2'd0, 2'd2);
    cycle(0, 0, 0, 0, 32'h0, 2'd0, 2'd2);
    cycle(0, 0, 0, 0, 32'h0, 2'd0, 2'd2);
    check("occ_one", occupancy, 4'd1);
    cycle(0, 0, 0, 1, 32'h200, 2'd2, 2'd2);
    check("wrap_occ", occupancy, 4'd2);
    check("wrap_dec_pc", dec_pc, 64'h0000_0204_0000_0200);
    cycle(0, 0, 0, 0, 32'h0, 2'd0, 2'd2);

    // Zero-count packet is a no-op; oversize count stores FETCH_WIDTH.
    cycle(0, 0, 0, 1, 32'h400, 2'd0, 2'd0);
    check("cnt_zero", occupancy, 4'd0);
    cycle(0, 0, 0, 1, 32'h410, 2'd3, 2'd0);
    cycle(0, 0, 0, 1, 32'h420, 2'd1, 2'd3);

    // Reset mid-operation with a live write discards everything.
    cycle(1, 0, 0, 1, 32'h700, 2'd2, 2'd0);
    check("midrst_occ", occupancy, 4'd0);

`ifdef FETCH_BUFFER_PERF_EN
    cycle(1, 0, 0, 0, 32'h0, 2'd0, 2'd0);
    for (int p = 0; p < 4; p++) cycle(0, 0, 0, 1, 32'h800 + 32'(8 * p), 2'd2, 2'd0);
    cycle(0, 0, 0, 0, 32'h0, 2'd0, 2'd0);
    cycle(0, 0, 0, 0, 32'h0, 2'd0, 2'd0);
    cycle(0, 1, 0, 0, 32'h0, 2'd0, 2'd0);
    check("perf_full", full_cycles, 32'd3);
    check("perf_hwm", occ_hwm, 4'd8);
    cycle(0, 0, 0, 0, 32'h0, 2'd0, 2'd0);
    check("perf_full_hold", full_cycles, 32'd3);
`endif

    // Random traffic against the scoreboard.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom % 60) == 0, ($urandom % 30) == 0, ($urandom % 8) == 0,
            ($urandom % 4) != 0, {$urandom} & 32'hFFFF_FFFC,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
